// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_align load/store unit.
// LSU_MISALIGNED_SPLIT_EN adds the REQ2/WAIT2 second-beat states.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
`ifdef LSU_MISALIGNED_SPLIT_EN
        REQ2  = 3'd4,
        WAIT2 = 3'd5,
`endif
        RESP  = 3'd3
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// Core-side request/response and memory-side bus of lsu_align.
// slave = the load/store unit, master = core plus memory environment.
interface lsu_align_if #(parameter int XLEN = 32);
    localparam int NB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misaligned;
    logic            resp_illegal;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            busy;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

endinterface

// File: rtl/lsu_align_lane.sv
// Lane steering for lsu_align: byte enables and store data over a two-word
// window, and load extraction/extension from a merged two-word read.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB  = XLEN / 8,
    localparam int OW  = $clog2(NB)
) (
    input  logic [2:0]        funct3,
    input  logic [OW-1:0]     off,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata_lo,
    input  logic [XLEN-1:0]   rdata_hi,
    output logic [2*NB-1:0]   be,
    output logic [2*XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0]   rdata_ext
);

    localparam logic [7:0] XLEN_B = 8'(XLEN);

    logic [3:0]      size_s;
    logic [2*NB-1:0] mask_s;
    logic [XLEN-1:0] low_s;
    logic [XLEN-1:0] shl_s;
    logic [7:0]      bits_s;
    logic [7:0]      sh_s;
    logic            sext_s;

    // Upper half of be/wdata_sh is the second beat; extension is done by
    // parking the access MSB at bit XLEN-1 and shifting back down.
    always_comb begin
        size_s = size_bytes(funct3);
        mask_s = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask_s[i] = (i < int'(size_s));
        end
        be       = mask_s << off;
        wdata_sh = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        low_s    = XLEN'({rdata_hi, rdata_lo} >> {off, 3'b000});
        bits_s   = {1'b0, size_s, 3'b000};
        if (bits_s >= XLEN_B) begin
            sh_s = 8'd0;
        end else begin
            sh_s = XLEN_B - bits_s;
        end
        sext_s = (funct3 == LB) || (funct3 == LH) || (funct3 == LW);
        shl_s  = low_s << sh_s;
        if (sext_s) begin
            rdata_ext = $unsigned($signed(shl_s) >>> sh_s);
        end else begin
            rdata_ext = shl_s >> sh_s;
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit: one request at a time, word-aligned handshaked memory port.
// LSU_MISALIGNED_SPLIT_EN turns misaligned faults into one- or two-beat accesses.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    lsu_align_if.slave bus
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_t      state_r;
    lsu_state_t      state_next_s;
    lsu_state_t      after_beat1_s;
    logic            write_r;
    logic [2:0]      funct3_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] hi_s;
    logic            illegal_r;
    logic            misal_r;
    logic            accept_s;
    logic            illegal_in_s;
    logic            misal_in_s;
    logic            misal_rep_s;
    logic            fault_in_s;
    logic            cap_lo_s;
    logic            cap_hi_s;
    logic            beat2_s;
    logic            mem_req_s;
    logic [3:0]      size_in_s;
    logic [XLEN-1:0] word_addr_s;
    logic [2*NB-1:0] be_s;
    logic [2*XLEN-1:0] wdata_sh_s;
    logic [XLEN-1:0] rdata_ext_s;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic            split_r;
    logic            split_in_s;
    logic [XLEN-1:0] hi_r;
    logic [OW-1:0]   off_in_s;
`endif

    // Classify the incoming request; misalignment is only reported for legal types.
    always_comb begin
        size_in_s    = size_bytes(bus.req_funct3);
        illegal_in_s = (bus.req_funct3 == 3'b111)
                    || (bus.req_write && bus.req_funct3[2])
                    || ((XLEN == 32) && ((bus.req_funct3 == LD) || (bus.req_funct3 == LWU)));
        misal_in_s   = !illegal_in_s && ((bus.req_addr[3:0] & (size_in_s - 4'd1)) != 4'd0);
        accept_s     = (state_r == IDLE) && bus.req_valid;
`ifdef LSU_MISALIGNED_SPLIT_EN
        off_in_s     = bus.req_addr[OW-1:0];
        split_in_s   = (5'(off_in_s) + 5'(size_in_s)) > 5'(NB);
        misal_rep_s  = 1'b0;
        fault_in_s   = illegal_in_s;
`else
        misal_rep_s  = misal_in_s;
        fault_in_s   = illegal_in_s || misal_in_s;
`endif
    end

    // Request latch: everything the memory side sees comes from these fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_r   <= 1'b0;
            funct3_r  <= 3'b000;
            addr_r    <= '0;
            wdata_r   <= '0;
            illegal_r <= 1'b0;
            misal_r   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            write_r   <= bus.req_write;
            funct3_r  <= bus.req_funct3;
            addr_r    <= bus.req_addr;
            wdata_r   <= bus.req_wdata;
            illegal_r <= illegal_in_s;
            misal_r   <= misal_rep_s;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_r   <= split_in_s && !fault_in_s;
`endif
        end
    end

    // Read-word capture for the first and (optionally) second beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r <= '0;
        end else if (cap_lo_s) begin
            lo_r <= bus.mem_rdata;
        end
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    // Second-beat read-word capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= '0;
        end else if (cap_hi_s) begin
            hi_r <= bus.mem_rdata;
        end
    end
    assign hi_s = hi_r;
`else
    assign hi_s = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; rvalid alongside gnt captures and skips the wait state.
    always_comb begin
        state_next_s = state_r;
        cap_lo_s     = 1'b0;
        cap_hi_s     = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        after_beat1_s = split_r ? REQ2 : RESP;
`else
        after_beat1_s = RESP;
`endif
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next_s = fault_in_s ? RESP : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (!bus.mem_gnt) begin
                    state_next_s = REQ;
                end else if (write_r) begin
                    state_next_s = after_beat1_s;
                end else if (bus.mem_rvalid) begin
                    cap_lo_s     = 1'b1;
                    state_next_s = after_beat1_s;
                end else begin
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    cap_lo_s     = 1'b1;
                    state_next_s = after_beat1_s;
                end else begin
                    state_next_s = WAIT;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            REQ2: begin
                if (!bus.mem_gnt) begin
                    state_next_s = REQ2;
                end else if (write_r) begin
                    state_next_s = RESP;
                end else if (bus.mem_rvalid) begin
                    cap_hi_s     = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT2;
                end
            end
            WAIT2: begin
                if (bus.mem_rvalid) begin
                    cap_hi_s     = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT2;
                end
            end
`endif
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    lsu_lane_align #(.XLEN(XLEN)) u_lane (
        .funct3    (funct3_r),
        .off       (addr_r[OW-1:0]),
        .wdata     (wdata_r),
        .rdata_lo  (lo_r),
        .rdata_hi  (hi_s),
        .be        (be_s),
        .wdata_sh  (wdata_sh_s),
        .rdata_ext (rdata_ext_s)
    );

    // Output decode from state and latched fields only.
    always_comb begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        beat2_s = (state_r == REQ2);
`else
        beat2_s = 1'b0;
`endif
        mem_req_s     = (state_r == REQ) || beat2_s;
        word_addr_s   = {addr_r[XLEN-1:OW], {OW{1'b0}}};
        bus.req_ready = (state_r == IDLE);
        bus.busy      = (state_r != IDLE);
        if (mem_req_s) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = write_r;
            bus.mem_addr  = beat2_s ? (word_addr_s + XLEN'(NB)) : word_addr_s;
            bus.mem_be    = beat2_s ? be_s[2*NB-1:NB] : be_s[NB-1:0];
            bus.mem_wdata = !write_r ? '0
                          : (beat2_s ? wdata_sh_s[2*XLEN-1:XLEN] : wdata_sh_s[XLEN-1:0]);
        end else begin
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_be    = '0;
            bus.mem_wdata = '0;
        end
        if (state_r == RESP) begin
            bus.resp_valid      = 1'b1;
            bus.resp_illegal    = illegal_r;
            bus.resp_misaligned = misal_r;
            bus.resp_rdata      = (write_r || illegal_r || misal_r) ? '0 : rdata_ext_s;
        end else begin
            bus.resp_valid      = 1'b0;
            bus.resp_illegal    = 1'b0;
            bus.resp_misaligned = 1'b0;
            bus.resp_rdata      = '0;
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align (XLEN=32): directed table, reset-abort sequence and
// randomized requests checked against a byte-level reference model.
module tb_lsu_align;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_align_if #(.XLEN(32)) bus();

    lsu_align #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        ill;
        logic        mis;
        int          nbeats;
        logic [31:0] addr0, addr1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd, w0, w1;
        int          gdly, rdly;
        logic        ill, mis;
        logic [31:0] rdata;
        logic [3:0]  be0;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte-level view of the access: which lanes of which word it touches.
    function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, wd, w0, w1);
        exp_t e;
        int size, off;
        logic fault;
        logic [63:0] sh, mem2;
        logic [31:0] res;
        e = '{default: '0};
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        e.ill = (f3 == 3'b111) || (f3 == 3'b011) || (f3 == 3'b110) || (wr && f3[2]);
        e.mis = !e.ill && ((addr % size) != 0);
        fault = e.ill || e.mis;
`ifdef LSU_MISALIGNED_SPLIT_EN
        fault = e.ill;
        e.mis = 1'b0;
`endif
        if (!fault) begin
            e.nbeats = (off + size > 4) ? 2 : 1;
            e.addr0  = {addr[31:2], 2'b00};
            e.addr1  = e.addr0 + 32'd4;
            for (int k = 0; k < size; k++) begin
                if (off + k < 4) e.be0[off + k] = 1'b1;
                else             e.be1[off + k - 4] = 1'b1;
            end
            sh    = {32'h0, wd} << (8 * off);
            e.wd0 = sh[31:0];
            e.wd1 = sh[63:32];
            if (!wr) begin
                mem2 = {w1, w0};
                res  = 32'h0;
                for (int k = 0; k < size; k++) res[8*k +: 8] = mem2[8*(off+k) +: 8];
                if (!f3[2] && res[8*size-1]) begin
                    for (int b = 8 * size; b < 32; b++) res[b] = 1'b1;
                end
                e.rdata = res;
            end
        end
        return e;
    endfunction

    // One request with a responding memory: gdly stall cycles before gnt, rvalid rdly cycles after.
    task automatic run_op(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, wd, w0, w1, input int gdly, rdly,
                          output logic o_ill, o_mis, output logic [31:0] o_rdata,
                          output logic [3:0] o_be0);
        exp_t e;
        int cyc, beats, stall, pend, exp_lat;
        logic done;
        logic [31:0] rword;
        e = model(wr, f3, addr, wd, w0, w1);
        o_ill = 1'b0; o_mis = 1'b0; o_rdata = 32'h0; o_be0 = 4'h0;
        check({tag, " req_ready idle"}, bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        step();
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        cyc = 1; beats = 0; stall = 0; pend = 0; done = 1'b0; rword = 32'h0;
        while (!done && cyc < 60) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (bus.resp_valid) begin
                done = 1'b1;
            end else begin
                check({tag, " req_ready busy"}, bus.req_ready, 1'b0);
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rword;
                    end
                end else if (bus.mem_req) begin
                    if (beats >= e.nbeats) begin
                        check({tag, " unexpected mem_req"}, 1'b1, 1'b0);
                    end else begin
                        check({tag, " mem_addr"}, bus.mem_addr, beats == 0 ? e.addr0 : e.addr1);
                        check({tag, " mem_be"},   bus.mem_be,   beats == 0 ? e.be0 : e.be1);
                        check({tag, " mem_we"},   bus.mem_we,   wr);
                        if (wr) check({tag, " mem_wdata"}, bus.mem_wdata, beats == 0 ? e.wd0 : e.wd1);
                    end
                    if (beats == 0) o_be0 = bus.mem_be;
                    if (stall == gdly) begin
                        bus.mem_gnt = 1'b1;
                        rword = (beats == 0) ? w0 : w1;
                        stall = 0;
                        beats++;
                        if (!wr) begin
                            if (rdly == 0) begin
                                bus.mem_rvalid = 1'b1;
                                bus.mem_rdata  = rword;
                            end else begin
                                pend = rdly;
                            end
                        end
                    end else begin
                        stall++;
                    end
                end
                step();
                cyc++;
            end
        end
        if (!done) begin
            check({tag, " resp timeout"}, 1'b0, 1'b1);
        end else begin
            exp_lat = (e.nbeats == 0) ? 1 : e.nbeats * (1 + gdly) + (wr ? 0 : e.nbeats * rdly) + 1;
            o_ill   = bus.resp_illegal;
            o_mis   = bus.resp_misaligned;
            o_rdata = bus.resp_rdata;
            check({tag, " resp_illegal"},    bus.resp_illegal,    e.ill);
            check({tag, " resp_misaligned"}, bus.resp_misaligned, e.mis);
            check({tag, " resp_rdata"},      bus.resp_rdata,      e.rdata);
            check({tag, " beats"},           beats,               e.nbeats);
            check({tag, " latency"},         cyc,                 exp_lat);
            step();
            check({tag, " resp pulse"},      bus.resp_valid,      1'b0);
            check({tag, " ready after"},     bus.req_ready,       1'b1);
        end
    endtask

    vec_t        tbl[16];
    logic        a_ill, a_mis;
    logic [31:0] a_rdata;
    logic [3:0]  a_be;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 4'hF};
        tbl[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 4'h8};
        tbl[2]  = '{1'b0, 3'b000, 32'h102, 32'h0, 32'h00800000, 32'h0, 0, 1, 1'b0, 1'b0, 32'hFFFFFF80, 4'h4};
        tbl[3]  = '{1'b0, 3'b100, 32'h102, 32'h0, 32'h00800000, 32'h0, 0, 1, 1'b0, 1'b0, 32'h00000080, 4'h4};
        tbl[4]  = '{1'b0, 3'b001, 32'h100, 32'h0, 32'h0000FFFE, 32'h0, 3, 1, 1'b0, 1'b0, 32'hFFFFFFFE, 4'h3};
`ifdef LSU_MISALIGNED_SPLIT_EN
        tbl[5]  = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h3344ABCD, 32'h99881122, 0, 1, 1'b0, 1'b0, 32'h11223344, 4'hC};
        tbl[10] = '{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 4'h6};
`else
        tbl[5]  = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h3344ABCD, 32'h99881122, 0, 1, 1'b0, 1'b1, 32'h0, 4'h0};
        tbl[10] = '{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 32'h0, 4'h0};
`endif
        tbl[6]  = '{1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[7]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[8]  = '{1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[9]  = '{1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[11] = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h80000001, 32'h0, 0, 0, 1'b0, 1'b0, 32'h80000001, 4'hF};
        tbl[12] = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h7FFF0000, 32'h0, 1, 2, 1'b0, 1'b0, 32'h00007FFF, 4'hC};
        tbl[13] = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80010000, 32'h0, 0, 1, 1'b0, 1'b0, 32'h00008001, 4'hC};
        tbl[14] = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 32'h0, 0, 1, 1'b0, 1'b0, 32'h0000007F, 4'h2};
        tbl[15] = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 32'h0, 1, 0, 1'b0, 1'b0, 32'h0, 4'hC};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        step();
        step();
        check("reset req_ready",  bus.req_ready,  1'b1);
        check("reset busy",       bus.busy,       1'b0);
        check("reset mem_req",    bus.mem_req,    1'b0);
        check("reset mem_be",     bus.mem_be,     4'h0);
        check("reset resp_valid", bus.resp_valid, 1'b0);
        check("reset resp_rdata", bus.resp_rdata, 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                   tbl[i].w0, tbl[i].w1, tbl[i].gdly, tbl[i].rdly, a_ill, a_mis, a_rdata, a_be);
            check($sformatf("vec%0d tbl illegal", i),    a_ill,   tbl[i].ill);
            check($sformatf("vec%0d tbl misaligned", i), a_mis,   tbl[i].mis);
            check($sformatf("vec%0d tbl rdata", i),      a_rdata, tbl[i].rdata);
            check($sformatf("vec%0d tbl be", i),         a_be,    tbl[i].be0);
        end

        // Reset while waiting for read data, then a stray rvalid.
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h100;
        step();
        bus.req_valid  = 1'b0;
        check("abort mem_req", bus.mem_req, 1'b1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check("abort wait busy",    bus.busy,    1'b1);
        check("abort wait mem_req", bus.mem_req, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy",      bus.busy,       1'b0);
        check("abort mem_req",   bus.mem_req,    1'b0);
        check("abort req_ready", bus.req_ready,  1'b1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFEF00D;
        step();
        bus.mem_rvalid = 1'b0;
        check("stray rvalid resp",  bus.resp_valid, 1'b0);
        step();
        check("stray rvalid resp2", bus.resp_valid, 1'b0);
        check("stray rvalid busy",  bus.busy,       1'b0);

        for (int i = 0; i < 300; i++) begin
            run_op($sformatf("rnd%0d", i), 1'($urandom % 2), 3'($urandom % 8), $urandom,
                   $urandom, $urandom, $urandom, int'($urandom % 3), int'($urandom % 3),
                   a_ill, a_mis, a_rdata, a_be);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Parametrised load/store unit between the multicycle core datapath and a word-wide data memory.
- Takes one load/store request at a time (RISC-V funct3 encodings). Drives a handshaked memory port using word-aligned addresses and byte enables.
- Lane-shifts store data. Extracts and sign/zero-extends load data.
- Reports misaligned and illegal accesses. Replaces ad-hoc address masking in the datapath.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- NB, XLEN/8, bytes per memory word (derived; not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  unit can accept (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  access type: LB/LH/LW/LD/LBU/LHU/LWU; stores use the low 2 bits
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load result; 0 for stores and faults
- resp_misaligned  out  1  valid with resp_valid
- resp_illegal  out  1  valid with resp_valid
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  XLEN  word-aligned address (low log2(NB) bits zero)
- mem_be  out  NB  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State IDLE.
- States: IDLE, REQ, WAIT, RESP; REQ2 and WAIT2 exist only with the optional feature.
- IDLE: on req_valid, latch request and go to REQ.
  - If faulting (see below), go directly to RESP with no memory traffic.
- Fault rules:
  - size = 1/2/4/8 bytes from funct3[1:0]; off = addr mod NB.
  - Illegal: funct3 = 111; or LD/SD/LWU when XLEN=32; or store with funct3[2]=1.
  - Misaligned: addr not a multiple of size.
- REQ: mem_req=1 with mem_addr/mem_be/mem_we/mem_wdata held stable until mem_gnt.
  - On gnt: a store goes to RESP; a load goes to WAIT.
- WAIT: on mem_rvalid, capture lanes and go to RESP.
  - mem_rvalid in the same cycle as gnt is legal: capture and skip WAIT.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready is low in every non-IDLE state.
- Byte enables and data:
  - mem_be = ((1<<size)-1) << off, truncated to NB.
  - mem_wdata = req_wdata << 8*off.
  - Load result = (mem_rdata >> 8*off) sign-extended from size (LB/LH/LW), or zero-extended (LBU/LHU/LWU, and LD).
- Latency, zero wait states:
  - Store: accept at cycle 0, gnt at cycle 1, resp at cycle 2.
  - Load with rvalid one cycle after gnt: resp at cycle 3.
- Reset mid-operation: state is IDLE after the next edge; mem_req drops. A stray mem_rvalid in IDLE is ignored. No resp_valid is produced for the aborted request.
- Outputs are registered from state/latched fields; no combinational path from req_* to mem_*.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned accesses are never faulted.
  - If off+size <= NB: single access with shifted be.
  - If off+size > NB: two beats.
    - Beat 1 (REQ/WAIT): word addr, be upper lanes.
    - Beat 2 (REQ2/WAIT2): word addr+NB, be = remaining low lanes, store data = req_wdata >> 8*(NB-off).
    - Load bytes are merged little-endian across both beats before extension.
  - resp_misaligned is always 0.
- Undefined: misaligned accesses fault as above; REQ2/WAIT2 are absent.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - state enum lsu_state_t.
  - function size_bytes(funct3).
- Sub-module lsu_lane_align: combinational be/wdata shift and rdata extract/extend, parametrised by XLEN.

Test Plan:
- SW 0xDEADBEEF @0x100, gnt immediate -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF; resp_valid at cycle 2, rdata 0.
- SB 0x000000A5 @0x103 -> be 1000, wdata 0xA5000000; LB @0x102 with rdata 0x00800000 -> 0xFFFFFF80; LBU -> 0x00000080.
- LW @0x102:
  - Without the feature -> no mem_req, resp_misaligned=1.
  - With the feature -> beat 0x100 be 1100 and beat 0x104 be 0011; words 0x3344xxxx and 0xxxxx1122 -> rdata 0x11223344.
- LH @0x100, gnt stalled 3 cycles -> mem_* stable, req_ready=0; rvalid with 0x0000FFFE -> 0xFFFFFFFE.
- Reset asserted in WAIT -> next cycle busy=0, mem_req=0; later mem_rvalid produces no resp_valid.
- funct3=111 load, or LD at XLEN=32 -> resp_illegal=1 one cycle after accept; no mem_req.
